serial_rx: RTL
==============

// Module: serial_rx
// PURPOSE
//   UART-style 8N1 serial receiver: deserialises the single-bit output stream driven by
//   top (idle-high, start bit 0, data LSB first, stop bit 1) into bytes. Used on the
//   board/test side to recover what the chip emits on uo_out[0].
//   Delivers bytes through a one-entry valid/ready holding register with error flags.
// PARAMETERS
//   CLKS_PER_BIT  16  clk cycles per serial bit; must be >= 4 and even
//   DATA_BITS     8   data bits per frame (1..8)
// PORTS
//   clk          in   1          single clock; all state on rising edge
//   nrst         in   1          asynchronous, active-low reset
//   rx_i         in   1          serial line, asynchronous to clk, idle high
//   data_o       out  DATA_BITS  received byte; stable while valid_o=1
//   valid_o      out  1          byte available in holding register
//   ready_i      in   1          consumer accepts byte when valid_o & ready_i
//   frame_err_o  out  1          1-cycle pulse: stop bit sampled 0
//   overrun_o    out  1          1-cycle pulse: byte completed while holding reg full
// BEHAVIOUR
//   Reset (nrst=0, async): synchroniser flops=1, state=IDLE, counters=0, data_o=0,
//     valid_o=0, frame_err_o=0, overrun_o=0. Reset mid-frame discards the partial byte.
//   Sync: rx_i -> 2-flop synchroniser -> rx_s (2 cycles latency); FSM sees rx_s only.
//   Bit counter cnt counts 0..CLKS_PER_BIT-1; bit index idx counts 0..DATA_BITS-1.
//   IDLE:  rx_s=0 -> START, cnt=0. Otherwise stay.
//   START: at cnt=CLKS_PER_BIT/2-1 sample rx_s (bit centre). 1 -> IDLE (glitch,
//          no flags). 0 -> DATA, cnt=0, idx=0.
//   DATA:  at cnt=CLKS_PER_BIT-1 shift rx_s into shift reg MSB, shifting right (LSB
//          first); cnt=0; idx=DATA_BITS-1 -> STOP, else idx+1.
//   STOP:  at cnt=CLKS_PER_BIT-1 sample rx_s.
//          1 -> deliver byte (see below), -> IDLE.
//          0 -> frame_err_o=1 next cycle, byte discarded, -> BREAK.
//   BREAK: wait until rx_s=1, then -> IDLE (a held-low line never re-triggers START).
//   Delivery on good stop: if valid_o=0 or (valid_o & ready_i) this cycle: data_o<=byte,
//     valid_o<=1 next cycle. Else (valid_o & !ready_i): byte dropped, data_o unchanged,
//     overrun_o=1 next cycle.
//   Handshake: valid_o & ready_i with no new byte -> valid_o<=0 next cycle; data_o holds.
//     valid_o never drops without ready_i. ready_i while valid_o=0 is ignored.
//   Latency: rx_i falling edge to valid_o = 2 + CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT
//     + 1 cycles. Next START is detected from IDLE the cycle after STOP (stop-bit centre),
//     so back-to-back frames with 1 stop bit are received without loss.
//   Flags are single-cycle, never sticky; frame_err_o and overrun_o never both 1.
// STRUCTURE
//   serial_pkg: rx_state_t enum {IDLE, START, DATA, STOP, BREAK};
//     DEFAULT_CLKS_PER_BIT=16, DEFAULT_DATA_BITS=8; shared with any future transmitter.
//   Sub-module sync_2ff (reset value parameter, here 1) for the rx_i synchroniser.
//   cnt width $clog2(CLKS_PER_BIT); idx width $clog2(DATA_BITS)+1 (no truncation at 1..8).
// TESTING  (CLKS_PER_BIT=8, DATA_BITS=8, ready_i=1 unless stated)
//   Single byte 0xA5 framed 0,1,0,1,0,0,1,0,1,1 -> valid_o 1 cycle, data_o=0xA5,
//     rising exactly 2+4+72+1=79 cycles after rx_i falls; no flags.
//   Glitch: rx_i low 3 cycles then high -> state returns IDLE, valid_o, flags stay 0.
//   Frame error: send 0x3C with stop=0, line held low 40 cycles -> frame_err_o 1 cycle,
//     no valid_o, no new frame until rx_i returns high; next 0x81 received correctly.
//   Back-to-back 0x00,0xFF,0x55 with one stop bit each -> three valid_o, correct order.
//   Overrun: ready_i=0, send 0x11 then 0x22 -> data_o=0x11 held, overrun_o 1 cycle at
//     second stop; raise ready_i -> valid_o drops next cycle, 0x22 never appears.
//   Reset mid-DATA (nrst low 1 cycle after 4th bit) -> all outputs 0 immediately;
//     following full frame 0x7E received correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared serial-link types and defaults for the receiver and any future transmitter.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic nrst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_rx.sv
// 8N1-style serial receiver: samples bit centres of an idle-high line and hands bytes
// out through a one-entry valid/ready holding register with frame-error/overrun pulses.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int CNTW = $clog2(CLKS_PER_BIT);
  localparam int IDXW = $clog2(DATA_BITS) + 1;
  localparam logic [CNTW-1:0] CNT_HALF = CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(DATA_BITS - 1);

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d_i  (rx_i),
    .q_o  (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [CNTW-1:0]      cnt_q, cnt_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, sh_next;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 deliver;

  // LSB arrives first, so each new bit enters at the MSB and the register shifts right.
  always_comb begin
    sh_next = sh_q;
    for (int i = 0; i < DATA_BITS - 1; i++) sh_next[i] = sh_q[i+1];
    sh_next[DATA_BITS-1] = rx_s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    deliver = 1'b0;

    if (valid_q && ready_i) valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          sh_d  = sh_next;
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A full register that is being drained this cycle can take the new byte.
    if (deliver) begin
      if (!valid_q || ready_i) begin
        data_d  = sh_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule
